load_align_unit: RTL and testbench

Parametrised, multi-cycle load data path between the MEM stage and a word-addressed data memory with one-cycle read latency. It accepts a byte address and a load type, and issues one or two word reads; two reads are needed when the access crosses a word boundary. It then merges, shifts and sign- or zero-extends the result, and returns one XLEN-wide value to the writeback path. The block generalises byte-select extension to any XLEN (32/64), adds the 64-bit load types, and handles misaligned loads in hardware.

---
 rtl/load_align_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_align_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load data path: word reads, merge, shift and extend
//
// Purpose:
//   Accepts a byte address and RISC-V load type from the MEM stage. It issues
//   one or two word reads to a one-cycle-latency data memory, then aligns and
//   sign/zero-extends the result for writeback.
//
// Build option:
//   MISALIGNED_LOAD_EN - when defined, word-crossing loads are split into two
//                        reads and merged. When undefined, any load whose
//                        offset is not a multiple of its size faults.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_addr              byte address
//   req_type              funct3 load type
//   req_rd                destination tag
//   mem_en/mem_addr       word read strobe and word address
//   mem_rdata             read data, valid the cycle after mem_en
//   resp_valid            one-cycle result pulse
//   resp_data, resp_rd    result value and tag
//   load_err              one-cycle fault pulse (illegal type or misaligned)
//   busy                  high whenever not idle
module load_align_unit #(
  parameter int XLEN  = 32,
  parameter int BYTES = XLEN / 8,
  parameter int OFFW  = $clog2(BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [2:0]           req_type,
  input  logic [4:0]           req_rd,
  output logic                 mem_en,
  output logic [XLEN-OFFW-1:0] mem_addr,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_data,
  output logic [4:0]           resp_rd,
  output logic                 load_err,
  output logic                 busy
);

`ifdef MISALIGNED_LOAD_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LO, S_RESP, S_ERR, S_HI} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LO, S_RESP, S_ERR} state_t;
`endif

  state_t                state_q, state_d;
  logic [XLEN-OFFW-1:0]  word_q;
  logic [OFFW-1:0]       off_q;
  logic [2:0]            type_q;
  logic [4:0]            rd_q;
  logic [XLEN-1:0]       lo_q;

  // Request decode (only meaningful in IDLE).
  logic [OFFW:0]   req_size;
  logic [OFFW-1:0] req_off;
  logic            req_illegal;
  logic            req_fault;

  assign req_size = (OFFW+1)'(1) << req_type[1:0];
  assign req_off  = req_addr[OFFW-1:0];

  always_comb begin
    req_illegal = (req_type == 3'b111);
    if (XLEN == 32 && (req_type == 3'b011 || req_type == 3'b110)) begin
      req_illegal = 1'b1;
    end
  end

`ifdef MISALIGNED_LOAD_EN
  logic [OFFW:0]   size_q;
  logic [XLEN-1:0] hi_q;
  logic [OFFW:0]   end_off;
  logic            cross;

  assign req_fault = req_illegal;
  // The access spills into the next word when its last byte lies beyond it.
  assign end_off   = {1'b0, off_q} + size_q;
  assign cross     = end_off > (OFFW+1)'(BYTES);
`else
  logic req_misal;

  // size is a power of two, so off mod size is off & (size-1). For
  // size == BYTES the low bits are 0 and the decrement yields all ones.
  assign req_misal = (req_off & (req_size[OFFW-1:0] - OFFW'(1))) != '0;
  assign req_fault = req_illegal | req_misal;
`endif

  // Next-state and control outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    resp_valid = 1'b0;
    load_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_fault ? S_ERR : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = word_q;
        state_d  = S_LO;
      end
      S_LO: begin
`ifdef MISALIGNED_LOAD_EN
        if (cross) begin
          // Second read overlaps with capture of the first; the +1 wraps
          // naturally at the top word address.
          mem_en   = 1'b1;
          mem_addr = word_q + 1'b1;
          state_d  = S_HI;
        end else begin
          state_d = S_RESP;
        end
`else
        state_d = S_RESP;
`endif
      end
`ifdef MISALIGNED_LOAD_EN
      S_HI: begin
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        load_err = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      off_q   <= '0;
      type_q  <= '0;
      rd_q    <= '0;
      lo_q    <= '0;
`ifdef MISALIGNED_LOAD_EN
      size_q  <= '0;
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        word_q <= req_addr[XLEN-1:OFFW];
        off_q  <= req_off;
        type_q <= req_type;
        rd_q   <= req_rd;
`ifdef MISALIGNED_LOAD_EN
        size_q <= req_size;
        // hi stays zero for non-crossing loads so the merge is uniform.
        hi_q   <= '0;
`endif
      end
      if (state_q == S_LO) begin
        lo_q <= mem_rdata;
      end
`ifdef MISALIGNED_LOAD_EN
      if (state_q == S_HI) begin
        hi_q <= mem_rdata;
      end
`endif
    end
  end

  // Data formation: shift {hi,lo} right by off bytes, keep size bytes, extend.
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic            sgn;
  logic            fill;
  int              nbits;

`ifdef MISALIGNED_LOAD_EN
  logic [2*XLEN-1:0] merged;
  assign merged  = {hi_q, lo_q} >> {off_q, 3'b000};
  assign shifted = merged[XLEN-1:0];
`else
  assign shifted = lo_q >> {off_q, 3'b000};
`endif

  always_comb begin
    sgn   = shifted[XLEN-1];
    nbits = XLEN;
    case (type_q[1:0])
      2'd0: begin sgn = shifted[7];  nbits = 8;  end
      2'd1: begin sgn = shifted[15]; nbits = 16; end
      2'd2: begin sgn = shifted[31]; nbits = 32; end
      default: begin sgn = shifted[XLEN-1]; nbits = XLEN; end
    endcase
    fill = sgn & ~type_q[2];
    ext  = '0;
    for (int i = 0; i < XLEN; i++) begin
      ext[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

  assign resp_data = (state_q == S_RESP) ? ext  : '0;
  assign resp_rd   = (state_q == S_RESP) ? rd_q : '0;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - self-checking bench for load_align_unit (XLEN=32)
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_rd;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        load_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  load_align_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_type(req_type), .req_rd(req_rd),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    logic [31:0] w;
    case (wa)
      30'd0:   w = 32'h44332211;
      30'd1:   w = 32'h88776655;
      default: w = ({2'b00, wa} * 32'h9E3779B1) ^ 32'hC3A5_5A3C;
    endcase
    return w;
  endfunction

  // One-cycle-latency word memory.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_word(mem_addr);
  end

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference: assemble bytes little-endian, then extend arithmetically.
  task automatic model(input logic [31:0] a, input logic [2:0] t,
                       output bit err, output bit cr, output logic [31:0] val);
    int     size;
    bit     illegal;
    bit     misal;
    longint v;
    size    = 1 << t[1:0];
    illegal = (t == 3'b111) || (t == 3'b011) || (t == 3'b110);
    misal   = (a % size) != 0;
    cr      = ((a % 4) + size) > 4;
`ifdef MISALIGNED_LOAD_EN
    err = illegal;
`else
    err = illegal || misal;
`endif
    v = 0;
    for (int k = 0; k < size && k < 4; k++) begin
      v = v + (longint'(byte_at(a + k)) << (8 * k));
    end
    if (!t[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) begin
      v = v - (longint'(1) << (8 * size));
    end
    val = v[31:0];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input logic [31:0] a, input logic [2:0] t,
                          input logic [4:0] rd, input string tag);
    bit          e_err;
    bit          e_cr;
    logic [31:0] e_val;
    int          n_en, n_resp, n_err, resp_cyc, err_cyc;
    logic        busy1, ready2;
    logic [31:0] data;
    logic [4:0]  rdo;
    logic [29:0] addrs[$];
    logic [29:0] w0, w1;
    model(a, t, e_err, e_cr, e_val);
    n_en = 0; n_resp = 0; n_err = 0; resp_cyc = 0; err_cyc = 0;
    busy1 = 1'b0; ready2 = 1'b0; data = '0; rdo = '0;
    @(negedge clk);
    check({tag, " ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_type = t; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_type = 3'($urandom); req_rd = 5'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_en) addrs.push_back(mem_addr);
      if (mem_en) n_en++;
      if (resp_valid) begin n_resp++; resp_cyc = c; data = resp_data; rdo = resp_rd; end
      if (load_err) begin n_err++; err_cyc = c; end
      if (c == 1) busy1 = busy;
      if (c == 2) ready2 = req_ready;
    end
    check({tag, " busy"}, busy1, 1);
    w0 = a[31:2];
    w1 = w0 + 30'd1;
    if (e_err) begin
      check({tag, " err_cycle"}, err_cyc, 1);
      check({tag, " err_count"}, n_err, 1);
      check({tag, " no_mem_en"}, n_en, 0);
      check({tag, " no_resp"}, n_resp, 0);
      check({tag, " ready_after_err"}, ready2, 1);
    end else begin
      check({tag, " no_err"}, n_err, 0);
      check({tag, " resp_count"}, n_resp, 1);
      check({tag, " resp_cycle"}, resp_cyc, e_cr ? 4 : 3);
      check({tag, " data"}, data, e_val);
      check({tag, " rd"}, rdo, rd);
      check({tag, " mem_en_count"}, n_en, e_cr ? 2 : 1);
      check({tag, " addr0"}, (addrs.size() > 0) ? addrs[0] : 30'bx, w0);
      if (e_cr) check({tag, " addr1"}, (addrs.size() > 1) ? addrs[1] : 30'bx, w1);
    end
  endtask

  initial begin
    int n_bad;
    logic [31:0] ra;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_type = '0; req_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 1);
    check("reset mem_en", mem_en, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_data", resp_data, 0);
    check("reset resp_rd", resp_rd, 0);
    check("reset load_err", load_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;

    // Directed scenarios from the memory image word0/word1.
    run_load(32'd3, 3'b000, 5'd1, "LB@3");
    run_load(32'd7, 3'b000, 5'd2, "LB@7");
    run_load(32'd2, 3'b101, 5'd3, "LHU@2");
    run_load(32'd6, 3'b001, 5'd17, "LH@6");
    run_load(32'd1, 3'b010, 5'd4, "LW@1");
    run_load(32'd3, 3'b001, 5'd5, "LH@3");
    run_load(32'hFFFF_FFFF, 3'b001, 5'd6, "LH@top");
    run_load(32'hFFFF_FFFD, 3'b010, 5'd7, "LW@top");
    run_load(32'd0, 3'b011, 5'd8, "LD@0");
    run_load(32'd4, 3'b110, 5'd9, "LWU@4");
    run_load(32'd0, 3'b111, 5'd10, "T111");
    run_load(32'd4, 3'b010, 5'd11, "LW@4");

    // Reset during LO aborts the access.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'd0; req_type = 3'b010; req_rd = 5'd12;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort in_lo busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort req_ready", req_ready, 1);
    check("abort busy", busy, 0);
    check("abort mem_en", mem_en, 0);
    check("abort resp_valid", resp_valid, 0);
    rst = 1'b0;
    n_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || load_err || mem_en) n_bad++;
    end
    check("abort quiet", n_bad, 0);
    run_load(32'd0, 3'b000, 5'd13, "LB@0 after abort");

    // Random loads near word 0 and near the top of the address space.
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15))
                                       : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      run_load(ra, 3'($urandom_range(0, 7)), 5'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
